// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES SPI master
// Contents: state_t (transfer FSM states), BLOCK_W_DEF (default word width),
//           CNT_W (bit counter width).
package aes_pkg;
    localparam int BLOCK_W_DEF = 128;
    localparam int CNT_W = 7;
    typedef enum logic [2:0] {IDLE, DATA, GAP, KEY, FIN} state_t;
endpackage

// File: rtl/aes_spi_clkgen.sv
// aes_spi_clkgen: serial clock divider with one-cycle rise/fall strobes
// Ports: clk, rst (async, active-high), en (run while a phase is active),
//        sclk (idle low, toggles every DIV clk cycles while en),
//        rise/fall (high in the clk cycle whose edge toggles sclk up/down).
module aes_spi_clkgen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    logic [7:0] cnt;
    logic tick;
    // Strobes are combinational so the master acts on the same edge that moves sclk.
    assign tick = en && cnt == 8'(DIV - 1);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sclk <= !sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI master sending a data word (cs1) then a key word (cs2) to an AES slave
// Ports: clk, rst (async, active-high), start (load data_in/key_in when idle),
//        data_in/key_in (words to send), cs1/cs2 (active-low selects),
//        sclk/mosi (serial clock idle low, MSB-first data), misod/misok (return data),
//        data_back/key_back (words returned by the slave), busy, done (one-cycle pulse).
module aes_spi_master
    import aes_pkg::*;
#(
    parameter int DIV = 2,
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [BLOCK_W-1:0] key_in,
    output logic               cs1,
    output logic               cs2,
    output logic               sclk,
    output logic               mosi,
    input  logic               misod,
    input  logic               misok,
    output logic [BLOCK_W-1:0] data_back,
    output logic [BLOCK_W-1:0] key_back,
    output logic               busy,
    output logic               done
);
    state_t state;
    logic [BLOCK_W-1:0] tx, key_tx, rx_d, rx_k;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0] gap_cnt;
    logic en, rise, fall, last;

    assign en = state == DATA || state == KEY;
    // bit_cnt advances on each falling edge, so it equals the index of the bit in flight.
    assign last = bit_cnt == CNT_W'(BLOCK_W - 1);

    aes_spi_clkgen #(.DIV(DIV)) clkgen (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sclk(sclk),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cs1 <= 1'b1;
            cs2 <= 1'b1;
            mosi <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            data_back <= '0;
            key_back <= '0;
            tx <= '0;
            key_tx <= '0;
            rx_d <= '0;
            rx_k <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tx <= data_in;
                    key_tx <= key_in;
                    mosi <= data_in[BLOCK_W-1];
                    cs1 <= 1'b0;
                    busy <= 1'b1;
                    bit_cnt <= '0;
                    state <= DATA;
                end
                DATA, KEY: begin
                    if (rise && state == DATA) rx_d <= {rx_d[BLOCK_W-2:0], misod};
                    if (rise && state == KEY) rx_k <= {rx_k[BLOCK_W-2:0], misok};
                    if (fall && !last) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx <= tx << 1;
                        mosi <= tx[BLOCK_W-2];
                    end
                    if (fall && last && state == DATA) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        cs1 <= 1'b1;
                        state <= GAP;
                    end
                    if (fall && last && state == KEY) begin
                        bit_cnt <= '0;
                        cs2 <= 1'b1;
                        mosi <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                        data_back <= rx_d;
                        key_back <= rx_k;
                        state <= FIN;
                    end
                end
                GAP: if (gap_cnt == 8'(DIV - 1)) begin
                    tx <= key_tx;
                    mosi <= key_tx[BLOCK_W-1];
                    cs2 <= 1'b0;
                    state <= KEY;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: randomized self-checking bench for aes_spi_master at DIV=1 and DIV=2
module tb_aes_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start[2];
    logic [127:0] data_in[2], key_in[2], data_back[2], key_back[2];
    logic cs1[2], cs2[2], sclk[2], mosi[2], misod[2], misok[2], busy[2], done[2];
    logic [127:0] sw_d[2], sw_k[2], so_d[2], so_k[2], cap_d[2], cap_k[2];
    int nd[2], nk[2];
    bit pcs1[2] = '{1'b1, 1'b1};
    bit pcs2[2] = '{1'b1, 1'b1};
    bit psclk[2] = '{1'b0, 1'b0};
    bit pmosi[2] = '{1'b0, 1'b0};
    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int last_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance g runs with DIV = g+1; each has its own slave model.
    for (genvar g = 0; g < 2; g++) begin : u
        aes_spi_master #(.DIV(g + 1)) dut (
            .clk(clk),
            .rst(rst),
            .start(start[g]),
            .data_in(data_in[g]),
            .key_in(key_in[g]),
            .cs1(cs1[g]),
            .cs2(cs2[g]),
            .sclk(sclk[g]),
            .mosi(mosi[g]),
            .misod(misod[g]),
            .misok(misok[g]),
            .data_back(data_back[g]),
            .key_back(key_back[g]),
            .busy(busy[g]),
            .done(done[g])
        );
        assign misod[g] = so_d[g][127];
        assign misok[g] = so_k[g][127];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Slave: load its return word on select fall, capture mosi and advance its
    // output on each sclk rise; also watch the bus-level invariants.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (pcs1[g] && !cs1[g]) begin nd[g] = 0; so_d[g] = sw_d[g]; end
            if (pcs2[g] && !cs2[g]) begin nk[g] = 0; so_k[g] = sw_k[g]; end
            if (!psclk[g] && sclk[g]) begin
                if (!cs1[g]) begin
                    cap_d[g] = {cap_d[g][126:0], mosi[g]};
                    so_d[g] = so_d[g] << 1;
                    nd[g]++;
                end else if (!cs2[g]) begin
                    cap_k[g] = {cap_k[g][126:0], mosi[g]};
                    so_k[g] = so_k[g] << 1;
                    nk[g]++;
                end
            end
            check("cs_excl", 128'(cs1[g] | cs2[g]), 128'd1);
            if (psclk[g] && sclk[g]) check("mosi_hold", 128'(mosi[g]), 128'(pmosi[g]));
            pcs1[g] = cs1[g];
            pcs2[g] = cs2[g];
            psclk[g] = sclk[g];
            pmosi[g] = mosi[g];
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full transfer on instance g; called and returning on a negedge.
    task automatic xfer(input int g, input bit hold, input bit pulses, input bit fixed);
        logic [127:0] d, kk, sd, sk;
        int k, div, c1f, c1l, c2f, c2l, dc;
        div = g + 1;
        d = fixed ? 128'h00112233445566778899aabbccddeeff : rnd128();
        kk = fixed ? 128'h000102030405060708090a0b0c0d0e0f : rnd128();
        sd = fixed ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a : rnd128();
        sk = fixed ? {128{1'b1}} : rnd128();
        sw_d[g] = sd;
        sw_k[g] = sk;
        data_in[g] = d;
        key_in[g] = kk;
        if (start[g]) k = last_done + 2;
        else begin
            start[g] = 1'b1;
            k = cyc + 1;
        end
        c1f = -1; c1l = -1; c2f = -1; c2l = -1; dc = -1;
        for (int n = 0; n < 3000 && dc < 0; n++) begin
            @(negedge clk);
            if (cyc == k) begin
                check("accept_cs1", 128'(cs1[g]), 128'd0);
                check("accept_busy", 128'(busy[g]), 128'd1);
                check("accept_mosi", 128'(mosi[g]), 128'(d[127]));
                data_in[g] = rnd128();
                key_in[g] = rnd128();
                if (!hold) start[g] = 1'b0;
            end
            if (pulses) start[g] = (cyc == k + 4 || cyc == k + 599);
            if (!cs1[g]) begin if (c1f < 0) c1f = cyc; c1l = cyc; end
            if (!cs2[g]) begin if (c2f < 0) c2f = cyc; c2l = cyc; end
            if (done[g]) dc = cyc;
        end
        check("done_cycle", 128'(dc), 128'(k + 513 * div));
        check("cs1_first", 128'(c1f), 128'(k));
        check("cs1_last", 128'(c1l), 128'(k + 256 * div - 1));
        check("cs2_first", 128'(c2f), 128'(k + 257 * div));
        check("cs2_last", 128'(c2l), 128'(k + 513 * div - 1));
        check("data_back", data_back[g], sd);
        check("key_back", key_back[g], sk);
        check("slave_data", cap_d[g], d);
        check("slave_key", cap_k[g], kk);
        check("data_rises", 128'(nd[g]), 128'd128);
        check("key_rises", 128'(nk[g]), 128'd128);
        check("fin_busy", 128'(busy[g]), 128'd0);
        @(negedge clk);
        check("done_width", 128'(done[g]), 128'd0);
        check("hold_data_back", data_back[g], sd);
        if (!hold) check("idle_busy", 128'(busy[g]), 128'd0);
        last_done = dc;
    endtask

    // Start a transfer on instance g and hit it with async reset mid data phase.
    task automatic abort_xfer(input int g);
        int k;
        bit seen;
        data_in[g] = rnd128();
        key_in[g] = rnd128();
        start[g] = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start[g] = 1'b0;
        for (int n = 0; n < 400 && !(cyc >= k + 299 && sclk[g]); n++) @(negedge clk);
        check("abort_pre_cs1", 128'(cs1[g]), 128'd0);
        check("abort_pre_sclk", 128'(sclk[g]), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_cs1", 128'(cs1[g]), 128'd1);
        check("abort_cs2", 128'(cs2[g]), 128'd1);
        check("abort_sclk", 128'(sclk[g]), 128'd0);
        check("abort_mosi", 128'(mosi[g]), 128'd0);
        check("abort_busy", 128'(busy[g]), 128'd0);
        check("abort_data_back", data_back[g], 128'd0);
        check("abort_key_back", key_back[g], 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            seen |= done[g] | busy[g];
        end
        check("abort_no_done", 128'(seen), 128'd0);
    endtask

    initial begin
        start = '{1'b0, 1'b0};
        data_in = '{128'd0, 128'd0};
        key_in = '{128'd0, 128'd0};
        sw_d = '{128'd0, 128'd0};
        sw_k = '{128'd0, 128'd0};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_cs1", 128'(cs1[g]), 128'd1);
            check("rst_cs2", 128'(cs2[g]), 128'd1);
            check("rst_sclk", 128'(sclk[g]), 128'd0);
            check("rst_mosi", 128'(mosi[g]), 128'd0);
            check("rst_busy", 128'(busy[g]), 128'd0);
            check("rst_done", 128'(done[g]), 128'd0);
            check("rst_data_back", data_back[g], 128'd0);
            check("rst_key_back", key_back[g], 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        xfer(1, 1'b0, 1'b0, 1'b1);
        xfer(0, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            xfer(0, 1'b0, 1'b0, 1'b0);
            xfer(1, 1'b0, 1'b0, 1'b0);
        end
        xfer(1, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("pulse_idle_busy", 128'(busy[1]), 128'd0);
        end
        abort_xfer(1);
        xfer(1, 1'b0, 1'b0, 1'b0);
        repeat (3) xfer(1, 1'b1, 1'b0, 1'b0);
        start[1] = 1'b0;
        repeat (2) xfer(0, 1'b1, 1'b0, 1'b0);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("end_busy0", 128'(busy[0]), 128'd0);
        check("end_busy1", 128'(busy[1]), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/aes_spi_master.md
AES_SPI_MASTER -- requirements
Module: aes_spi_master

Interface
REQ-001 SHALL have parameter DIV, default 2, meaning clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter BLOCK_W, default 128, meaning bits per transfer phase.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request to load one data/key pair.
REQ-006 SHALL have port data_in  in  BLOCK_W  plaintext or ciphertext word to send.
REQ-007 SHALL have port key_in  in  BLOCK_W  key word to send.
REQ-008 SHALL have ports cs1, cs2  out  1 each  active-low selects: cs1 for the data register, cs2 for the key register.
REQ-009 SHALL have ports sclk, mosi  out  1 each  serial clock (idle low) and serial data, MSB first.
REQ-010 SHALL have ports misod, misok  in  1 each  return serial data from the AES data and key registers.
REQ-011 SHALL have ports data_back, key_back  out  BLOCK_W each  words shifted out of the slave.
REQ-012 SHALL have ports busy, done  out  1 each  transfer in progress; one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, DATA, GAP, KEY, FIN.
REQ-014 In IDLE, start=1 at posedge k SHALL latch data_in/key_in into tx registers and enter DATA; cs1=0, mosi=data_in[BLOCK_W-1] and busy=1 SHALL appear at k+1.
REQ-015 Within DATA/KEY: sclk SHALL toggle every DIV cycles starting low; on each rising sclk edge SHALL sample misod (DATA) or misok (KEY) into the rx LSB with left shift; on each falling edge SHALL shift tx left and drive the next MSB on mosi.
REQ-016 A 7-bit bit counter SHALL count rising edges 0..BLOCK_W-1; the falling edge after count BLOCK_W-1 SHALL end the phase instead of shifting.
REQ-017 DATA end SHALL raise cs1, hold sclk=0, and enter GAP for exactly DIV cycles with cs1=cs2=1.
REQ-018 GAP exit SHALL drop cs2, drive mosi=key MSB, enter KEY.
REQ-019 Timing from start at k: cs1 low k+1..k+256*DIV; cs2 low k+1+257*DIV..k+513*DIV; FIN/done=1 at k+1+513*DIV (DIV=2: cycle k+1027).
REQ-020 FIN SHALL last one cycle: done=1, busy=0, data_back/key_back updated with rx registers, then IDLE.
REQ-021 start while busy=1 SHALL be ignored; start during FIN SHALL be ignored; start in IDLE the cycle after FIN SHALL be accepted.
REQ-022 data_back/key_back SHALL hold their last value until the next FIN; never partially updated.
REQ-023 cs1 and cs2 SHALL never be low simultaneously.
REQ-024 data_in/key_in changes after acceptance SHALL not affect the transfer in progress.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, cs1=cs2=1, sclk=0, mosi=0, busy=0, done=0, data_back=key_back=0, counters=0.
REQ-026 rst mid-transfer SHALL abort with no done pulse; first start after rst release SHALL begin a full fresh transfer.

Structure
REQ-027 SHALL place state enum, BLOCK_W default and counter width constant in shared package aes_pkg.
REQ-028 SHALL instantiate one sub-module aes_spi_clkgen (DIV counter producing sclk plus one-cycle rise/fall strobes, enabled only in DATA/KEY).

Verification
REQ-029 DIV=2, data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, slave model returning 69c4e0d86a7b0430d8cdb78070b4c55a on misod and all-ones on misok -> slave captures both words exactly; data_back=69c4...c55a, key_back=all-ones; done at k+1027.
REQ-030 DIV=1 same vectors -> done at k+514; sclk period 2 cycles; 128 rising edges per phase.
REQ-031 start pulsed at k+5 and k+600 during transfer -> ignored; exactly one done pulse.
REQ-032 rst asserted at k+300 (mid DATA) -> cs1=1, sclk=0 in same cycle without clk; no done; next start gives correct full transfer.
REQ-033 start held high continuously -> back-to-back transfers, new cs1 falling edge 2 cycles after each done.
REQ-034 Throughout all scenarios, assertion: never cs1=0 and cs2=0 together; mosi stable while sclk high.
